// File: rtl/cordic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cordic_pkg                                                                 |
// | Shared CORDIC constants (Q4.28 radians), arctangent table and state type.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cordic_pkg;

    localparam int ATAN_LEN = 12;
    localparam int CNT_W    = 4;

    // atan(2^-i) in Q4.28 radians
    localparam logic signed [31:0] ATAN_TABLE [0:ATAN_LEN-1] = '{
        32'sd210828714, 32'sd124459457, 32'sd65760959, 32'sd33381289,
        32'sd16755421,  32'sd8385878,   32'sd4193962,  32'sd2097109,
        32'sd1048570,   32'sd524287,    32'sd262143,   32'sd131071
    };

    localparam logic signed [31:0] PI_HALF  = 32'sd421657428;
    localparam logic signed [31:0] PI       = 32'sd843314857;
    localparam logic        [15:0] INV_GAIN = 16'd39797;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_COMP = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cordic_microrot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cordic_microrot                                                            |
// | Combinational single CORDIC micro-rotation on a WIDTH+2 bit x/y datapath.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cordic_microrot
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH+1:0] i_x,
    input  logic signed [WIDTH+1:0] i_y,
    input  logic signed [WIDTH-1:0] i_z,
    input  logic        [CNT_W-1:0] i_iter,
    input  logic                    i_dir_pos,
    output logic signed [WIDTH+1:0] o_x,
    output logic signed [WIDTH+1:0] o_y,
    output logic signed [WIDTH-1:0] o_z
);

    logic signed [WIDTH+1:0] w_x_sh;
    logic signed [WIDTH+1:0] w_y_sh;
    logic signed [WIDTH-1:0] w_atan;

    always_comb begin
        w_x_sh = i_x >>> i_iter;
        w_y_sh = i_y >>> i_iter;
        w_atan = WIDTH'(ATAN_TABLE[i_iter]);
        if (i_dir_pos) begin
            o_x = i_x + w_y_sh;
            o_y = i_y - w_x_sh;
            o_z = i_z + w_atan;
        end else begin
            o_x = i_x - w_y_sh;
            o_y = i_y + w_x_sh;
            o_z = i_z - w_atan;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_vectoring.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cordic_vectoring                                                           |
// | Iterative vectoring-mode CORDIC: (x, y) -> magnitude and atan2 phase.      |
// | Optional gain compensation stage: define CORDIC_GAIN_COMP_EN.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [WIDTH-1:0] magnitude,
    output logic signed [WIDTH-1:0] phase
);

    localparam int XW = WIDTH + 2;
    localparam logic signed [XW-1:0] MAG_MAX = XW'({1'b0, {(WIDTH-1){1'b1}}});

    state_t                  state_q, state_d;
    logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
    logic signed [WIDTH-1:0] z_q, z_d;
    logic        [CNT_W-1:0] i_q, i_d;
    logic                    zero_q, zero_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic        [WIDTH-1:0] mag_q, mag_d;
    logic signed [WIDTH-1:0] phase_q, phase_d;

    logic signed [XW-1:0]    w_x_ext, w_y_ext, w_x0, w_y0;
    logic signed [WIDTH-1:0] w_z0;
    logic signed [XW-1:0]    w_x_nx, w_y_nx;
    logic signed [WIDTH-1:0] w_z_nx;

    function automatic logic [WIDTH-1:0] sat_mag(input logic signed [XW-1:0] v);
        if (v[XW-1])
            return '0;
        else if (v > MAG_MAX)
            return MAG_MAX[WIDTH-1:0];
        else
            return v[WIDTH-1:0];
    endfunction

    // Fold left-half-plane inputs into the right half so the iterations converge
    always_comb begin
        w_x_ext = XW'(x_in);
        w_y_ext = XW'(y_in);
        if (x_in[WIDTH-1] && !y_in[WIDTH-1]) begin
            w_x0 = w_y_ext;
            w_y0 = -w_x_ext;
            w_z0 = WIDTH'(PI_HALF);
        end else if (x_in[WIDTH-1]) begin
            w_x0 = -w_y_ext;
            w_y0 = w_x_ext;
            w_z0 = -WIDTH'(PI_HALF);
        end else begin
            w_x0 = w_x_ext;
            w_y0 = w_y_ext;
            w_z0 = '0;
        end
    end

    cordic_microrot #(
        .WIDTH (WIDTH)
    ) u_microrot (
        .i_x       (x_q),
        .i_y       (y_q),
        .i_z       (z_q),
        .i_iter    (i_q),
        .i_dir_pos (!y_q[XW-1]),
        .o_x       (w_x_nx),
        .o_y       (w_y_nx),
        .o_z       (w_z_nx)
    );

`ifdef CORDIC_GAIN_COMP_EN
    localparam int PW = XW + 17;
    logic signed [PW-1:0] w_prod;
    logic signed [XW-1:0] w_comp;

    assign w_prod = PW'(x_q) * PW'($signed({1'b0, INV_GAIN}));
    assign w_comp = XW'(w_prod >>> 16);
`endif

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        i_d         = i_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        mag_d       = mag_q;
        phase_d     = phase_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d     = w_x0;
                    y_d     = w_y0;
                    z_d     = w_z0;
                    i_d     = '0;
                    zero_d  = (x_in == '0) && (y_in == '0);
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                x_d = w_x_nx;
                y_d = w_y_nx;
                z_d = w_z_nx;
                i_d = i_q + CNT_W'(1);
                if (i_q == CNT_W'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = S_COMP;
`else
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    mag_d       = zero_q ? '0 : sat_mag(w_x_nx);
                    phase_d     = zero_q ? '0 : w_z_nx;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            S_COMP: begin
                state_d     = S_DONE;
                out_valid_d = 1'b1;
                mag_d       = zero_q ? '0 : sat_mag(w_comp);
                phase_d     = zero_q ? '0 : z_q;
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            i_q         <= '0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            mag_q       <= '0;
            phase_q     <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            i_q         <= i_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            mag_q       <= mag_d;
            phase_q     <= phase_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign magnitude = mag_q;
    assign phase     = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_vectoring.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cordic_vectoring                                                        |
// | Directed self-checking bench for cordic_vectoring.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cordic_vectoring;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int EXP_LAT = 13;
    localparam int MAG_AX  = 1000000;
    localparam int MAG_DG  = 1414214;
`else
    localparam int EXP_LAT = 12;
    localparam int MAG_AX  = 1646760;
    localparam int MAG_DG  = 2328880;
`endif
    localparam int PH_TOL  = 262144;
    localparam int MAG_TOL = 64;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] x_in = '0;
    logic signed [31:0] y_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic        [31:0] magnitude;
    logic signed [31:0] phase;

    int n_checks = 0;
    int n_errors = 0;

    cordic_vectoring #(
        .WIDTH (32),
        .ITER  (12)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .magnitude (magnitude),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    // Launch one vector at a negedge and wait (bounded) for the result.
    task automatic do_op(input int x, input int y, output int mag, output int ph, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        x_in     = x;
        y_in     = y;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        mag = int'(magnitude);
        ph  = int'(phase);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (magnitude !== 32'd0) begin n_errors++; $display("FAIL reset_magnitude got=%0d exp=0", magnitude); end
        n_checks++;
        if (phase !== 32'sd0) begin n_errors++; $display("FAIL reset_phase got=%0d exp=0", phase); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_axis();
        int m, p, l;
        do_op(1000000, 0, m, p, l);
        n_checks++;
        if (l !== EXP_LAT) begin n_errors++; $display("FAIL axis_latency got=%0d exp=%0d", l, EXP_LAT); end
        n_checks++;
        if (p < -PH_TOL || p > PH_TOL) begin n_errors++; $display("FAIL axis_phase got=%0d exp=0+-%0d", p, PH_TOL); end
        n_checks++;
        if (m < MAG_AX - MAG_TOL || m > MAG_AX + MAG_TOL) begin
            n_errors++; $display("FAIL axis_magnitude got=%0d exp=%0d+-%0d", m, MAG_AX, MAG_TOL);
        end
        consume();
    endtask

    task automatic test_diagonal();
        int m, p, l;
        do_op(1000000, 1000000, m, p, l);
        n_checks++;
        if (l !== EXP_LAT) begin n_errors++; $display("FAIL diag_latency got=%0d exp=%0d", l, EXP_LAT); end
        n_checks++;
        if (p < 210828714 - PH_TOL || p > 210828714 + PH_TOL) begin
            n_errors++; $display("FAIL diag_phase got=%0d exp=210828714+-%0d", p, PH_TOL);
        end
        n_checks++;
        if (m < MAG_DG - MAG_TOL || m > MAG_DG + MAG_TOL) begin
            n_errors++; $display("FAIL diag_magnitude got=%0d exp=%0d+-%0d", m, MAG_DG, MAG_TOL);
        end
        consume();
    endtask

    task automatic test_quadrants();
        int xs [3] = '{-1000000, 0, -1000000};
        int ys [3] = '{0, -1000000, -1000000};
        int eph[3] = '{843314857, -421657428, -632486143};
        int emg[3] = '{MAG_AX, MAG_AX, MAG_DG};
        int m, p, l;
        for (int k = 0; k < 3; k++) begin
            do_op(xs[k], ys[k], m, p, l);
            n_checks++;
            if (p < eph[k] - PH_TOL || p > eph[k] + PH_TOL) begin
                n_errors++; $display("FAIL quad%0d_phase got=%0d exp=%0d+-%0d", k, p, eph[k], PH_TOL);
            end
            n_checks++;
            if (m < emg[k] - MAG_TOL || m > emg[k] + MAG_TOL) begin
                n_errors++; $display("FAIL quad%0d_magnitude got=%0d exp=%0d+-%0d", k, m, emg[k], MAG_TOL);
            end
            consume();
        end
        // the negative real axis must land on +pi, never -pi
        do_op(-5000, 0, m, p, l);
        n_checks++;
        if (p <= 0) begin n_errors++; $display("FAIL negaxis_sign got=%0d exp=positive", p); end
        consume();
    endtask

    task automatic test_zero_busy();
        int n;
        in_valid = 1'b1;
        x_in     = 0;
        y_in     = 0;
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 100) begin
            n_checks++;
            if (in_ready !== 1'b0) begin n_errors++; $display("FAIL busy_in_ready cycle=%0d got=%b exp=0", n, in_ready); end
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n !== EXP_LAT) begin n_errors++; $display("FAIL zero_latency got=%0d exp=%0d", n, EXP_LAT); end
        n_checks++;
        if (magnitude !== 32'd0) begin n_errors++; $display("FAIL zero_magnitude got=%0d exp=0", magnitude); end
        n_checks++;
        if (phase !== 32'sd0) begin n_errors++; $display("FAIL zero_phase got=%0d exp=0", phase); end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin n_errors++; $display("FAIL done_in_ready got=%b exp=0", in_ready); end
        consume();
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL consumed_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin n_errors++; $display("FAIL second_accept in_ready got=%b exp=0", in_ready); end
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        consume();
    endtask

    task automatic test_backpressure();
        int m, p, l;
        do_op(1000000, 1000000, m, p, l);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || int'(magnitude) !== m || int'(phase) !== p) begin
                n_errors++;
                $display("FAIL hold_stable cycle=%0d got v=%b m=%0d p=%0d exp v=1 m=%0d p=%0d",
                         k, out_valid, magnitude, phase, m, p);
            end
        end
        consume();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL pulse_out_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL pulse_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_reset_midop();
        int m, p, l;
        in_valid = 1'b1;
        x_in     = 1000000;
        y_in     = 1000000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++; $display("FAIL midreset_flags got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end
        n_checks++;
        if (magnitude !== 32'd0) begin n_errors++; $display("FAIL midreset_magnitude got=%0d exp=0", magnitude); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (14) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_partial got=%b exp=0", out_valid); end
        end
        do_op(-1000000, -1000000, m, p, l);
        n_checks++;
        if (l !== EXP_LAT) begin n_errors++; $display("FAIL postreset_latency got=%0d exp=%0d", l, EXP_LAT); end
        n_checks++;
        if (p < -632486143 - PH_TOL || p > -632486143 + PH_TOL) begin
            n_errors++; $display("FAIL postreset_phase got=%0d exp=-632486143+-%0d", p, PH_TOL);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_axis();
        test_diagonal();
        test_quadrants();
        test_zero_busy();
        test_backpressure();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
